// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT core: frame sizing, loader states
// and the real/imaginary layout of a complex sample.
package fft_pkg;

  localparam int unsigned LOG2_N_DEF = 10;
  localparam int unsigned DATA_W_DEF = 64;

  localparam int unsigned RE_MSB = 63;
  localparam int unsigned RE_LSB = 32;
  localparam int unsigned IM_MSB = 31;
  localparam int unsigned IM_LSB = 0;

  typedef enum logic {
    ACCEPT,
    WRITE
  } loader_state_t;

  function automatic logic [RE_MSB-RE_LSB:0] sample_re(input logic [DATA_W_DEF-1:0] s);
    return s[RE_MSB:RE_LSB];
  endfunction

  function automatic logic [IM_MSB-IM_LSB:0] sample_im(input logic [DATA_W_DEF-1:0] s);
    return s[IM_MSB:IM_LSB];
  endfunction

endpackage

// File: rtl/fft_bit_reverse.sv
// Combinational bit-reversal of a LOG2_N-bit index; shared by the input
// loader and the output unloader.
module fft_bit_reverse #(
  parameter int unsigned LOG2_N = 10
) (
  input  logic [LOG2_N-1:0] idx_i,
  output logic [LOG2_N-1:0] rev_o
);

  always_comb begin
    rev_o = '0;
    for (int unsigned k = 0; k < LOG2_N; k++) begin
      rev_o[k] = idx_i[LOG2_N-1-k];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// Streams complex samples into the FFT data RAM at bit-reversed addresses and
// pulses load_done once a full frame is resident.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_N = LOG2_N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fft_busy,
  output logic              ram_write_enable,
  output logic [LOG2_N-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic              ram_ready,
  output logic              load_done,
  output logic              frame_error,
  output logic [LOG2_N-1:0] sample_index
);

  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  loader_state_t     state_q, state_d;
  logic              last_q, last_d;
  logic [LOG2_N-1:0] addr_q, addr_d;
  logic [LOG2_N-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load_done_q, load_done_d;
  logic              frame_error_q, frame_error_d;
  logic [LOG2_N-1:0] rev_idx;
  logic              accept;
  logic              at_end;

  fft_bit_reverse #(.LOG2_N(LOG2_N)) u_bit_reverse (
    .idx_i (idx_q),
    .rev_o (rev_idx)
  );

  // Held low during reset so nothing upstream sees a phantom handshake.
  assign s_ready = (state_q == ACCEPT) && !fft_busy && !reset;
  assign accept  = s_valid && s_ready;
  assign at_end  = (idx_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    data_d        = data_q;
    load_done_d   = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          data_d  = s_data;
          last_d  = s_last;
          addr_d  = rev_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ram_ready) begin
          state_d       = ACCEPT;
          idx_d         = (at_end || last_q) ? '0 : idx_q + 1'b1;
          load_done_d   = at_end;
          frame_error_d = at_end ^ last_q;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q       <= ACCEPT;
      last_q        <= 1'b0;
      addr_q        <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      load_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      load_done_q   <= load_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign ram_write_enable = (state_q == WRITE);
  assign ram_address      = addr_q;
  assign ram_write_data   = data_q;
  assign load_done        = load_done_q;
  assign frame_error      = frame_error_q;
  assign sample_index     = idx_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: directed frame scenarios plus randomized
// transactions checked against a sample-level model of the loader.
module tb_fft_input_loader;

  localparam int LOG2_N = 10;
  localparam int N      = 1 << LOG2_N;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              fft_busy;
  logic              ram_write_enable;
  logic [LOG2_N-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_ready;
  logic              load_done;
  logic              frame_error;
  logic [LOG2_N-1:0] sample_index;

  always #5 clk = ~clk;

  fft_input_loader #(.LOG2_N(LOG2_N), .DATA_W(DATA_W)) dut (
    .MAX10_CLK1_50    (clk),
    .reset            (reset),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .fft_busy         (fft_busy),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_ready        (ram_ready),
    .load_done        (load_done),
    .frame_error      (frame_error),
    .sample_index     (sample_index)
  );

  typedef struct {
    int idx;
    int addr;
  } addr_vec_t;

  addr_vec_t tbl[6];

  int vectors = 0;
  int errors  = 0;
  int model_idx = 0;
  int ld_count  = 0;
  int fe_count  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model index %0d)", name, act, exp, model_idx);
    end
  endtask

  // Reference bit-reversal built arithmetically, LSB-first into MSB-first.
  function automatic int bitrev_ref(input int i);
    int r = 0;
    for (int k = 0; k < LOG2_N; k++) r = r * 2 + ((i >> k) & 1);
    return r;
  endfunction

  // One sample transaction. Starts and ends on a falling edge.
  task automatic send(input logic [63:0] d, input logic last, input int busy_cyc,
                      input int delay, input bit do_ready, input bit busy_in_write);
    logic [LOG2_N-1:0] exp_addr;
    bit exp_ld, exp_fe, busy_after;
    @(negedge clk);
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    fft_busy = (busy_cyc > 0);
    for (int c = 0; c < busy_cyc; c++) begin
      #1;
      chk("busy_s_ready", s_ready, 0);
      @(negedge clk);
      chk("busy_no_write", ram_write_enable, 0);
      chk("busy_index", sample_index, model_idx);
    end
    fft_busy = 1'b0;
    #1;
    chk("idle_s_ready", s_ready, 1);
    @(negedge clk);
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data   = {$urandom, $urandom};
    exp_addr = bitrev_ref(model_idx);
    chk("wr_enable", ram_write_enable, 1);
    chk("wr_address", ram_address, exp_addr);
    chk("wr_data", ram_write_data, d);
    chk("wr_s_ready", s_ready, 0);
    foreach (tbl[j]) if (tbl[j].idx == model_idx) chk("tbl_address", ram_address, tbl[j].addr);
    if (!do_ready) return;
    busy_after = busy_in_write;
    for (int c = 0; c < delay; c++) begin
      fft_busy = busy_after;
      @(negedge clk);
      chk("hold_enable", ram_write_enable, 1);
      chk("hold_address", ram_address, exp_addr);
      chk("hold_data", ram_write_data, d);
      chk("hold_s_ready", s_ready, 0);
    end
    fft_busy  = busy_after;
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    exp_ld    = (model_idx == N - 1);
    exp_fe    = (model_idx == N - 1) ^ last;
    model_idx = (model_idx == N - 1 || last) ? 0 : model_idx + 1;
    chk("load_done", load_done, exp_ld);
    chk("frame_error", frame_error, exp_fe);
    chk("next_index", sample_index, model_idx);
    chk("done_enable", ram_write_enable, 0);
    #1;
    chk("after_s_ready", s_ready, !busy_after);
    ld_count += int'(load_done);
    fe_count += int'(frame_error);
    fft_busy = 1'b0;
  endtask

  initial begin
    int ld0, fe0;
    tbl[0] = '{idx: 1,    addr: 512};
    tbl[1] = '{idx: 3,    addr: 768};
    tbl[2] = '{idx: 6,    addr: 384};
    tbl[3] = '{idx: 1023, addr: 1023};
    tbl[4] = '{idx: 0,    addr: 0};
    tbl[5] = '{idx: 2,    addr: 256};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    fft_busy = 1'b0; ram_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_enable", ram_write_enable, 0);
    chk("rst_address", ram_address, 0);
    chk("rst_data", ram_write_data, 0);
    chk("rst_index", sample_index, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_frame_error", frame_error, 0);
    reset = 1'b0;

    // Full frame, back-to-back, s_data = index, s_last on the final sample.
    ld_count = 0; fe_count = 0;
    for (int i = 0; i < N; i++) send(64'(i), i == N - 1, 0, 0, 1, 0);
    chk("frame_load_done_count", ld_count, 1);
    chk("frame_error_count", fe_count, 0);

    // Slow RAM: five-cycle stall.
    send(64'hDEAD_BEEF_0123_4567, 0, 0, 5, 1, 0);

    // Early s_last at index 9.
    ld0 = ld_count; fe0 = fe_count;
    while (model_idx != 9) send({$urandom, $urandom}, 0, 0, 0, 1, 0);
    send(64'h9, 1, 0, 0, 1, 0);
    chk("early_last_fe_count", fe_count - fe0, 1);
    chk("early_last_ld_count", ld_count - ld0, 0);
    send(64'hA5A5, 0, 0, 0, 1, 0);

    // fft_busy blocks accepts; fft_busy rising during WRITE does not abort it.
    send(64'h1111, 0, 3, 2, 1, 1);
    send(64'h2222, 0, 1, 0, 1, 1);

    // ram_ready while idle is ignored.
    @(negedge clk);
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    chk("stray_ready_index", sample_index, model_idx);
    chk("stray_ready_ld", load_done, 0);
    chk("stray_ready_fe", frame_error, 0);
    chk("stray_ready_enable", ram_write_enable, 0);

    // Reset while writing index 200.
    while (model_idx != 200) send({$urandom, $urandom}, 0, 0, $urandom_range(0, 1), 1, 0);
    send(64'hC8C8, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_idx = 0;
    chk("midrst_enable", ram_write_enable, 0);
    chk("midrst_index", sample_index, 0);
    chk("midrst_data", ram_write_data, 0);
    send(64'h5A5A, 0, 0, 0, 1, 0);

    // Missing s_last: randomized timing across a whole frame.
    while (model_idx != 0) send({$urandom, $urandom}, 0, 0, 0, 1, 0);
    ld0 = ld_count; fe0 = fe_count;
    for (int i = 0; i < N; i++)
      send({$urandom, $urandom}, 0, $urandom_range(0, 1), $urandom_range(0, 2), 1, 1'($urandom_range(0, 1)));
    chk("missing_last_ld", ld_count - ld0, 1);
    chk("missing_last_fe", fe_count - fe0, 1);
    chk("missing_last_index", sample_index, 0);

    // Random frames with randomly placed s_last.
    for (int i = 0; i < 300; i++)
      send({$urandom, $urandom}, ($urandom_range(0, 15) == 0), $urandom_range(0, 2),
           $urandom_range(0, 4), 1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
